// File: rtl/pc_gen.sv
// pc_gen: program-counter generator at the head of the fetch stage.
// Holds the architectural PC and selects the next PC from: exception vector,
// exception return, J-type jump, register jump, conditional branch, or PC+4.
// Optional build macro: ALIGN_CHECK_EN adds a misaligned-target trap on
// register jumps and exception returns (output misalign).
module pc_gen #(
  parameter int          WIDTH      = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             halt,
  input  logic [2:0]       BrOp,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic [15:0]      immi16,
  input  logic [25:0]      target,
  input  logic             Jump,
  input  logic             JumpReg,
  input  logic             exc_req,
  input  logic             eret,
  input  logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] NPC,
  output logic [WIDTH-1:0] PC_plus_4,
  output logic             fetch_valid,
  output logic             redirect,
  output logic [1:0]       state
`ifdef ALIGN_CHECK_EN
  ,
  output logic             misalign
`endif
);

  localparam logic [1:0] ST_BOOT = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_HALT = 2'b10;

  localparam logic [WIDTH-1:0] RESET_PC_W   = WIDTH'(RESET_PC);
  localparam logic [WIDTH-1:0] EXC_VECTOR_W = WIDTH'(EXC_VECTOR);

  // Signed branch condition; reserved and 000 encodings never take.
  function automatic logic br_eval(input logic [2:0] op,
                                   input logic signed [WIDTH-1:0] a,
                                   input logic signed [WIDTH-1:0] b);
    logic taken;
    taken = 1'b0;
    case (op)
      3'b001:  taken = (a == b);
      3'b010:  taken = (a != b);
      3'b011:  taken = (a <= 0);
      3'b100:  taken = (a > 0);
      3'b101:  taken = (a < 0);
      3'b110:  taken = (a >= 0);
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

  // Word offset sign-extended and scaled to bytes.
  function automatic logic signed [WIDTH-1:0] br_offset(input logic [15:0] imm);
    return {{(WIDTH-18){imm[15]}}, imm, 2'b00};
  endfunction

  logic [1:0]              state_q, state_d;
  logic [WIDTH-1:0]        pc_q, pc_d;
  logic [WIDTH-1:0]        pc_plus4;
  logic [WIDTH-1:0]        br_tgt;
  logic [WIDTH-1:0]        jmp_tgt;
  logic signed [WIDTH-1:0] rs_s, rt_s;
  logic                    br_taken;
  logic [WIDTH-1:0]        npc;
  logic                    redir;
`ifdef ALIGN_CHECK_EN
  logic                    mis;
`endif

  assign rs_s     = signed'(rs_data);
  assign rt_s     = signed'(rt_data);
  assign pc_plus4 = pc_q + WIDTH'(4);
  assign br_tgt   = pc_plus4 + $unsigned(br_offset(immi16));
  assign jmp_tgt  = {pc_q[WIDTH-1:28], target, 2'b00};
  assign br_taken = br_eval(BrOp, rs_s, rt_s);

  // Next-PC source selection in priority order; valid in every state.
  always_comb begin
    npc   = pc_plus4;
    redir = 1'b0;
`ifdef ALIGN_CHECK_EN
    mis   = 1'b0;
`endif
    if (exc_req) begin
      npc   = EXC_VECTOR_W;
      redir = 1'b1;
    end else if (eret) begin
      npc   = epc;
      redir = 1'b1;
`ifdef ALIGN_CHECK_EN
      if (epc[1:0] != 2'b00) begin
        npc = EXC_VECTOR_W;
        mis = 1'b1;
      end
`endif
    end else if (Jump) begin
      npc   = jmp_tgt;
      redir = 1'b1;
    end else if (JumpReg) begin
      npc   = rs_data;
      redir = 1'b1;
`ifdef ALIGN_CHECK_EN
      if (rs_data[1:0] != 2'b00) begin
        npc = EXC_VECTOR_W;
        mis = 1'b1;
      end
`endif
    end else if (br_taken) begin
      npc   = br_tgt;
      redir = 1'b1;
    end
  end

  // Control state and PC next-state: exceptions override stall and wake HALT.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (exc_req) begin
          pc_d = EXC_VECTOR_W;
        end else begin
          if (!stall) pc_d = npc;
          if (halt)   state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        if (exc_req) begin
          state_d = ST_RUN;
          pc_d    = EXC_VECTOR_W;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  // PC and state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC_W;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign PC          = pc_q;
  assign NPC         = npc;
  assign PC_plus_4   = pc_plus4;
  assign redirect    = redir;
  assign state       = state_q;
  assign fetch_valid = (state_q == ST_RUN) && !stall;
`ifdef ALIGN_CHECK_EN
  assign misalign    = mis;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Testbench for pc_gen: vector table with a PC scoreboard plus hand-written
// reset, stall, halt and mid-operation reset sequences.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n, stall, halt;
  logic [2:0]  BrOp;
  logic [31:0] rs_data, rt_data, epc;
  logic [15:0] immi16;
  logic [25:0] target;
  logic        Jump, JumpReg, exc_req, eret;
  logic [31:0] PC, NPC, PC_plus_4;
  logic        fetch_valid, redirect;
  logic [1:0]  state;
`ifdef ALIGN_CHECK_EN
  logic        misalign;
`endif

  int checks = 0;
  int errors = 0;

  pc_gen dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .halt(halt), .BrOp(BrOp),
    .rs_data(rs_data), .rt_data(rt_data), .immi16(immi16), .target(target),
    .Jump(Jump), .JumpReg(JumpReg), .exc_req(exc_req), .eret(eret), .epc(epc),
    .PC(PC), .NPC(NPC), .PC_plus_4(PC_plus_4), .fetch_valid(fetch_valid),
    .redirect(redirect), .state(state)
`ifdef ALIGN_CHECK_EN
    , .misalign(misalign)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [31:0] start;
    logic [2:0]  op;
    logic [31:0] rs, rt;
    logic [15:0] imm;
    logic [25:0] tg;
    logic        j, jr, ex, er, stl;
    logic [31:0] ep;
    logic [31:0] exp_npc;
    logic        exp_red;
    logic        exp_mis;
    logic [31:0] exp_pc;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] pc;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic clear_in();
    stall = 0; halt = 0; BrOp = 3'b000; rs_data = 0; rt_data = 0; epc = 0;
    immi16 = 0; target = 0; Jump = 0; JumpReg = 0; exc_req = 0; eret = 0;
  endtask

  task automatic addv(input string n, input logic [31:0] st, input logic [2:0] op,
                      input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm,
                      input logic [25:0] tg, input logic j, input logic jr, input logic ex,
                      input logic er, input logic stl, input logic [31:0] ep,
                      input logic [31:0] enpc, input logic ered, input logic emis,
                      input logic [31:0] epcv);
    vec_t v;
    v.name = n; v.start = st; v.op = op; v.rs = rs; v.rt = rt; v.imm = imm;
    v.tg = tg; v.j = j; v.jr = jr; v.ex = ex; v.er = er; v.stl = stl; v.ep = ep;
    v.exp_npc = enpc; v.exp_red = ered; v.exp_mis = emis; v.exp_pc = epcv;
    vecs.push_back(v);
  endtask

  // Move the PC to an aligned start address through a register jump.
  task automatic set_pc(input logic [31:0] v);
    clear_in();
    JumpReg = 1; rs_data = v;
    @(posedge clk); #1;
    chk("set_pc", PC, v);
    clear_in();
  endtask

  task automatic run_vec(input vec_t v);
    sb_t e;
    set_pc(v.start);
    BrOp = v.op; rs_data = v.rs; rt_data = v.rt; immi16 = v.imm; target = v.tg;
    Jump = v.j; JumpReg = v.jr; exc_req = v.ex; eret = v.er; stall = v.stl; epc = v.ep;
    #1;
    chk({v.name, "_npc"}, NPC, v.exp_npc);
    chk({v.name, "_redirect"}, {31'd0, redirect}, {31'd0, v.exp_red});
    chk({v.name, "_pc4"}, PC_plus_4, v.start + 32'd4);
`ifdef ALIGN_CHECK_EN
    chk({v.name, "_misalign"}, {31'd0, misalign}, {31'd0, v.exp_mis});
`endif
    e.name = {v.name, "_pc"}; e.pc = v.exp_pc;
    sb.push_back(e);
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty actual=0 expected=1");
    end else begin
      e = sb.pop_front();
      chk(e.name, PC, e.pc);
    end
    clear_in();
  endtask

  initial begin
    logic [31:0] mis_npc;
    logic        mis_flag;
`ifdef ALIGN_CHECK_EN
    mis_npc = 32'h0000_4180; mis_flag = 1'b1;
`else
    mis_npc = 32'h0000_3002; mis_flag = 1'b0;
`endif
    //   name          start         op     rs            rt     imm      tg         j  jr ex er st epc           npc           red mis pc
    addv("beq_t",     32'h3010, 3'b001, 32'd5,        32'd5, 16'hFFFE, 26'h0,     0, 0, 0, 0, 0, 32'h0,        32'h300C,     1, 0, 32'h300C);
    addv("bne_nt",    32'h3010, 3'b010, 32'd5,        32'd5, 16'hFFFE, 26'h0,     0, 0, 0, 0, 0, 32'h0,        32'h3014,     0, 0, 32'h3014);
    addv("bgez_nt",   32'h3010, 3'b110, 32'h8000_0000,32'd0, 16'h0004, 26'h0,     0, 0, 0, 0, 0, 32'h0,        32'h3014,     0, 0, 32'h3014);
    addv("bltz_t",    32'h3010, 3'b101, 32'h8000_0000,32'd0, 16'h0004, 26'h0,     0, 0, 0, 0, 0, 32'h0,        32'h3024,     1, 0, 32'h3024);
    addv("blez_t",    32'h3010, 3'b011, 32'd0,        32'd0, 16'h0001, 26'h0,     0, 0, 0, 0, 0, 32'h0,        32'h3018,     1, 0, 32'h3018);
    addv("bgtz_nt",   32'h3010, 3'b100, 32'd0,        32'd0, 16'h0001, 26'h0,     0, 0, 0, 0, 0, 32'h0,        32'h3014,     0, 0, 32'h3014);
    addv("bgtz_t",    32'h3010, 3'b100, 32'd1,        32'd0, 16'h0002, 26'h0,     0, 0, 0, 0, 0, 32'h0,        32'h301C,     1, 0, 32'h301C);
    addv("brop111",   32'h3010, 3'b111, 32'd5,        32'd5, 16'h0002, 26'h0,     0, 0, 0, 0, 0, 32'h0,        32'h3014,     0, 0, 32'h3014);
    addv("j_over_jr", 32'h3020, 3'b000, 32'h5000,     32'd0, 16'h0000, 26'h100,   1, 1, 0, 0, 0, 32'h0,        32'h0000_0400,1, 0, 32'h0000_0400);
    addv("exc_stall", 32'h3020, 3'b000, 32'h5000,     32'd0, 16'h0000, 26'h100,   1, 1, 1, 0, 1, 32'h0,        32'h4180,     1, 0, 32'h4180);
    addv("exc_eret",  32'h3020, 3'b000, 32'd0,        32'd0, 16'h0000, 26'h0,     0, 0, 1, 1, 0, 32'h1234_5678,32'h4180,     1, 0, 32'h4180);
    addv("eret_j",    32'h3020, 3'b000, 32'd0,        32'd0, 16'h0000, 26'h100,   1, 0, 0, 1, 0, 32'h1234_5678,32'h1234_5678,1, 0, 32'h1234_5678);
    addv("jr_over_br",32'h3010, 3'b001, 32'h6000,     32'h6000,16'h0004,26'h0,    0, 1, 0, 0, 0, 32'h0,        32'h6000,     1, 0, 32'h6000);
    addv("wrap_seq",  32'hFFFF_FFFC,3'b000,32'd0,     32'd0, 16'h0000, 26'h0,     0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0);
    addv("wrap_br",   32'hFFFF_FFFC,3'b001,32'd0,     32'd0, 16'h0001, 26'h0,     0, 0, 0, 0, 0, 32'h0,        32'h4,        1, 0, 32'h4);
    addv("j_hi_bits", 32'hF000_0010,3'b000,32'd0,     32'd0, 16'h0000, 26'h1,     1, 0, 0, 0, 0, 32'h0,        32'hF000_0004,1, 0, 32'hF000_0004);
    addv("stall_j",   32'h3010, 3'b000, 32'd0,        32'd0, 16'h0000, 26'h100,   1, 0, 0, 0, 1, 32'h0,        32'h0000_0400,1, 0, 32'h3010);
    addv("jr_unalign",32'h3010, 3'b000, 32'h3002,     32'd0, 16'h0000, 26'h0,     0, 1, 0, 0, 0, 32'h0,        mis_npc,      1, mis_flag, mis_npc);

    // Reset: two cycles low, BOOT for one cycle, then RUN.
    clear_in();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", PC, 32'h3000);
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_fv", {31'd0, fetch_valid}, 32'd0);
    rst_n = 1;
    @(posedge clk); #1;
    chk("boot_pc", PC, 32'h3000);
    chk("run_state", {30'd0, state}, 32'd1);
    chk("run_fv", {31'd0, fetch_valid}, 32'd1);
    @(posedge clk); #1;
    chk("first_seq_pc", PC, 32'h3004);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Stall held three cycles with a pending jump, then released.
    set_pc(32'h3030);
    stall = 1; Jump = 1; target = 26'h100;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("stall_hold_pc", PC, 32'h3030);
      chk("stall_fv", {31'd0, fetch_valid}, 32'd0);
    end
    stall = 0;
    @(posedge clk); #1;
    chk("stall_release_pc", PC, 32'h0000_0400);

    // Halt: frozen through jump/eret, woken by exception.
    set_pc(32'h3040);
    halt = 1; stall = 1;
    @(posedge clk); #1;
    clear_in();
    chk("halt_state", {30'd0, state}, 32'd2);
    chk("halt_pc", PC, 32'h3040);
    chk("halt_fv", {31'd0, fetch_valid}, 32'd0);
    Jump = 1; target = 26'h100;
    #1;
    chk("halt_npc", NPC, 32'h0000_0400);
    @(posedge clk); #1;
    chk("halt_j_pc", PC, 32'h3040);
    clear_in();
    eret = 1; epc = 32'h5555_0000;
    @(posedge clk); #1;
    chk("halt_eret_pc", PC, 32'h3040);
    chk("halt_eret_state", {30'd0, state}, 32'd2);
    clear_in();
    exc_req = 1;
    @(posedge clk); #1;
    clear_in();
    chk("wake_pc", PC, 32'h4180);
    chk("wake_state", {30'd0, state}, 32'd1);
    chk("wake_fv", {31'd0, fetch_valid}, 32'd1);

    // Reset mid-operation discards a pending jump.
    Jump = 1; target = 26'h200; rst_n = 0;
    @(posedge clk); #1;
    chk("midrst_pc", PC, 32'h3000);
    chk("midrst_state", {30'd0, state}, 32'd0);
    rst_n = 1;
    clear_in();
    @(posedge clk); #1;
    chk("midrst_boot_pc", PC, 32'h3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator for the MIPS-style core.
- Holds the architectural PC register and computes the next PC from these sources: sequential, conditional branch (six compare types evaluated internally), J-type jump, register jump, exception vector and exception return.
- Adds stall, halt and a boot-cycle fetch-valid indication.
- Sits at the head of the fetch stage and drives the instruction-memory address.

Parameters:
- WIDTH, 32, PC/data width in bits; must be >= 32.
- RESET_PC, 32'h0000_3000, PC value loaded on reset, zero-extended to WIDTH.
- EXC_VECTOR, 32'h0000_4180, exception entry address, zero-extended to WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- stall  in  1  hold PC this cycle.
- halt  in  1  enter HALT state.
- BrOp  in  3  branch type: 000 none, 001 beq, 010 bne, 011 blez, 100 bgtz, 101 bltz, 110 bgez, 111 reserved (treated as none).
- rs_data  in  WIDTH  branch operand A / register-jump target.
- rt_data  in  WIDTH  branch operand B (beq/bne only).
- immi16  in  16  branch offset in words.
- target  in  26  J-type target field.
- Jump  in  1  J-type jump.
- JumpReg  in  1  jump to rs_data.
- exc_req  in  1  take exception.
- eret  in  1  return to epc.
- epc  in  WIDTH  exception return address.
- PC  out  WIDTH  current PC (registered).
- NPC  out  WIDTH  next PC (combinational).
- PC_plus_4  out  WIDTH  PC+4.
- fetch_valid  out  1  PC is a valid fetch address this cycle.
- redirect  out  1  NPC differs from PC_plus_4 due to a taken control transfer.
- state  out  2  00 BOOT, 01 RUN, 10 HALT.

Behaviour:
- Reset (rst_n=0 at posedge):
  - PC=RESET_PC, state=BOOT, fetch_valid=0.
  - Reset mid-operation discards any pending redirect.
- States:
  - BOOT → RUN unconditionally on the next edge. PC is not updated in BOOT, so the first fetch is RESET_PC.
  - RUN → HALT when halt=1 and exc_req=0.
  - HALT → RUN only when exc_req=1; PC loads EXC_VECTOR.
  - HALT ignores all other inputs and holds PC.
- fetch_valid = (state==RUN) && !stall.
- Arithmetic is modulo 2^WIDTH and wraps silently; no overflow flag.
  - PC_plus_4 = PC+4.
  - Branch target = PC+4+(sext(immi16)<<2).
  - Jump target = {PC[WIDTH-1:28], target, 2'b00}.
- Branch compares are signed, on rs_data:
  - beq: rs==rt.
  - bne: rs!=rt.
  - blez: rs<=0.
  - bgtz: rs>0.
  - bltz: rs<0.
  - bgez: rs>=0.
- NPC priority, highest first: exc_req → EXC_VECTOR; eret → epc; Jump → jump target; JumpReg → rs_data; branch taken → branch target; else PC_plus_4.
- redirect=1 for any of the first five sources. An exc_req landing on PC_plus_4 by coincidence still asserts redirect.
- PC update in RUN: PC<=NPC on every edge unless stall=1.
  - exc_req overrides stall: PC<=EXC_VECTOR even while stalled.
  - eret, Jump, JumpReg and branch are ignored while stalled; the requester must hold them.
- Simultaneous Jump+JumpReg: Jump wins. Simultaneous eret+exc_req: exception wins.
- NPC and redirect are combinationally valid in every state.
- Latency: one cycle from inputs to PC.

Optional Feature:
- Macro ALIGN_CHECK_EN.
- Defined: adds output misalign (1 bit, combinational).
  - When JumpReg or eret is the selected source and the target's bits [1:0] != 0, NPC=EXC_VECTOR, misalign=1 and redirect=1.
  - Otherwise misalign=0.
- Undefined: no port; low bits pass unchanged.

Test Plan:
- Reset: hold rst_n=0 two cycles, release → PC=0x3000, state BOOT with fetch_valid=0 for one cycle, then RUN; PC=0x3004 one cycle later.
- Branch set at PC=0x3010:
  - beq with rs=rt=5, immi16=0xFFFE → NPC=0x300C, redirect=1.
  - bne with same operands → NPC=0x3014, redirect=0.
  - bgez with rs=0x8000_0000 → not taken.
- Priority at PC=0x3020, Jump=1, target=0x0000100, JumpReg=1, rs=0x5000:
  - NPC=0x0000_0400.
  - Add exc_req=1 → NPC=0x4180, and PC takes 0x4180 even with stall=1.
- Stall/wrap:
  - stall=1 for 3 cycles with Jump=1 → PC unchanged.
  - PC=0xFFFF_FFFC with no transfer → next PC=0x0000_0000.
- Halt: halt=1 in RUN → HALT, fetch_valid=0, PC frozen through Jump/eret pulses; exc_req=1 → RUN with PC=0x4180.
- ALIGN_CHECK_EN: JumpReg with rs=0x3002 → misalign=1, PC=0x4180. Without the macro → PC=0x3002.
